// File: rtl/nco_freq_meter.sv
// Gated-window frequency meter: counts rising edges of an asynchronous input
// over GATE_CYCLES clk cycles and reports the count (Hz when GATE_CYCLES = CLK_HZ).
//
// state | meaning
// IDLE  | waiting for start, busy low
// GATE  | window open, counting synchronized rising edges of sig_in
module nco_freq_meter #(
    parameter int unsigned CLK_HZ      = 27000000,
    parameter int unsigned GATE_CYCLES = 27000000,
    parameter int unsigned CNT_W       = 32,
    parameter bit          CONTINUOUS  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_ovf
);

    localparam int unsigned   GW        = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0] GATE_LOAD = GW'(GATE_CYCLES - 1);

    if (GATE_CYCLES < 2 || CLK_HZ == 0) begin : g_param_check
        $error("nco_freq_meter: GATE_CYCLES must be >= 2 and CLK_HZ nonzero");
    end

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic             s1, s2, s3;
    logic             edge_pulse;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] edge_cnt, edge_cnt_inc;
    logic             sat, sat_inc;
    logic             gate_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_pulse = s2 & ~s3;
    assign gate_last  = (gate_cnt == '0);

    // Counter sticks at all-ones; an edge arriving there marks the window saturated.
    always_comb begin
        edge_cnt_inc = edge_cnt;
        sat_inc      = sat;
        if (edge_pulse) begin
            if (&edge_cnt) sat_inc = 1'b1;
            else           edge_cnt_inc = edge_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = GATE;
            GATE: if (gate_last && !CONTINUOUS) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == GATE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            sat        <= 1'b0;
            meas_valid <= 1'b0;
            meas_count <= '0;
            meas_ovf   <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    gate_cnt <= GATE_LOAD;
                    edge_cnt <= '0;
                    sat      <= 1'b0;
                end
            end else if (gate_last) begin
                // Final-cycle edge belongs to this window; reload for continuous mode.
                meas_valid <= 1'b1;
                meas_count <= edge_cnt_inc;
                meas_ovf   <= sat_inc;
                gate_cnt   <= GATE_LOAD;
                edge_cnt   <= '0;
                sat        <= 1'b0;
            end else begin
                gate_cnt <= gate_cnt - GW'(1);
                edge_cnt <= edge_cnt_inc;
                sat      <= sat_inc;
            end
        end
    end

endmodule

// File: tb/tb_nco_freq_meter.sv
// Testbench for nco_freq_meter: one-shot, saturating and continuous instances
// checked against an edge-counting reference built from sampled sig_in history.
module tb_nco_freq_meter;

    localparam int G  = 1000;
    localparam int NS = 40000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sig_in = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic        busy_a, busy_b, busy_c;
    logic        mv_a, mv_b, mv_c;
    logic [31:0] cnt_a, cnt_c;
    logic [3:0]  cnt_b;
    logic        ovf_a, ovf_b, ovf_c;

    nco_freq_meter #(.CLK_HZ(27000000), .GATE_CYCLES(G), .CNT_W(32), .CONTINUOUS(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start_a), .busy(busy_a),
        .meas_valid(mv_a), .meas_count(cnt_a), .meas_ovf(ovf_a));

    nco_freq_meter #(.CLK_HZ(27000000), .GATE_CYCLES(G), .CNT_W(4), .CONTINUOUS(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start_b), .busy(busy_b),
        .meas_valid(mv_b), .meas_count(cnt_b), .meas_ovf(ovf_b));

    nco_freq_meter #(.CLK_HZ(27000000), .GATE_CYCLES(G), .CNT_W(32), .CONTINUOUS(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start_c), .busy(busy_c),
        .meas_valid(mv_c), .meas_count(cnt_c), .meas_ovf(ovf_c));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit samp[NS];
    int hi_len = 5, lo_len = 5, ph = 0;
    bit sig_en = 1'b0;

    // sig_in level seen at each rising clk edge; forced low while reset holds the synchronizer.
    initial forever begin
        @(posedge clk);
        if (cyc < NS) samp[cyc] = rst_n ? sig_in : 1'b0;
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (!sig_en) begin
            sig_in = 1'b0;
            ph = 0;
        end else begin
            sig_in = (ph < hi_len);
            ph = (ph + 1 >= hi_len + lo_len) ? 0 : ph + 1;
        end
    end

    // Reference: a rising sig_in sampled at edges k-1 -> k produces a count at edge k+2.
    // Window after start at edge t covers edges t+1 .. t+g.
    function automatic int model_count(input int t, input int g);
        int n = 0;
        for (int j = t + 1; j <= t + g; j++)
            if (j >= 3 && j - 2 < NS && samp[j-2] && !samp[j-3]) n++;
        return n;
    endfunction

    function automatic logic mv(input int w);
        return (w == 0) ? mv_a : (w == 1) ? mv_b : mv_c;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_sig(input bit en, input int hi, input int lo);
        @(negedge clk);
        hi_len = hi;
        lo_len = lo;
        sig_en = en;
        wait_cycles(20);
    endtask

    task automatic do_start(input int w, output int t);
        @(negedge clk);
        case (w)
            0: start_a = 1'b1;
            1: start_b = 1'b1;
            default: start_c = 1'b1;
        endcase
        t = cyc;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
    endtask

    task automatic wait_valid(input int w, input int max, output int at, output bit ok);
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            if (mv(w)) begin
                ok = 1'b1;
                at = cyc;
            end
        end
    endtask

    task automatic test_reset();
        wait_cycles(4);
        checks++;
        if ({busy_a, mv_a, cnt_a, ovf_a} !== 35'd0) begin
            errors++;
            $display("FAIL reset_a: got busy=%b valid=%b count=%0d ovf=%b expected all 0", busy_a, mv_a, cnt_a, ovf_a);
        end
        checks++;
        if ({busy_b, mv_b, cnt_b, ovf_b} !== 7'd0) begin
            errors++;
            $display("FAIL reset_b: got busy=%b valid=%b count=%0d ovf=%b expected all 0", busy_b, mv_b, cnt_b, ovf_b);
        end
        checks++;
        if ({busy_c, mv_c, cnt_c, ovf_c} !== 35'd0) begin
            errors++;
            $display("FAIL reset_c: got busy=%b valid=%b count=%0d ovf=%b expected all 0", busy_c, mv_c, cnt_c, ovf_c);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(5);
    endtask

    task automatic test_oneshot(input string name, input bit en, input int hi, input int lo, input int exp);
        int t, at;
        bit ok;
        set_sig(en, hi, lo);
        do_start(0, t);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy: got %b expected 1", name, busy_a);
        end
        wait_valid(0, G + 50, at, ok);
        checks++;
        if (!ok || at - t != G + 1) begin
            errors++;
            $display("FAIL %s_latency: got %0d expected %0d", name, at - t, G + 1);
        end
        checks++;
        if (cnt_a !== exp || ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL %s_count: got %0d ovf=%b expected %0d ovf=0", name, cnt_a, ovf_a, exp);
        end
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_fall: got %b expected 0", name, busy_a);
        end
        wait_cycles(5);
        checks++;
        if (cnt_a !== exp || mv_a !== 1'b0) begin
            errors++;
            $display("FAIL %s_hold: got count=%0d valid=%b expected %0d valid=0", name, cnt_a, mv_a, exp);
        end
    endtask

    task automatic test_back_to_back();
        int t, t2, at;
        bit ok;
        set_sig(1'b1, 5, 5);
        do_start(0, t);
        wait_valid(0, G + 50, at, ok);
        start_a = 1'b1;
        t2 = cyc;
        @(negedge clk);
        start_a = 1'b0;
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b expected 1", busy_a);
        end
        wait_valid(0, G + 50, at, ok);
        checks++;
        if (!ok || at - t2 != G + 1 || cnt_a !== 32'd100) begin
            errors++;
            $display("FAIL b2b_second: got latency=%0d count=%0d expected latency=%0d count=100", at - t2, cnt_a, G + 1);
        end
    endtask

    task automatic test_restart_ignored();
        int t, at, extra;
        bit ok;
        set_sig(1'b1, 5, 5);
        do_start(0, t);
        while (cyc < t + 500) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_valid(0, G + 50, at, ok);
        checks++;
        if (!ok || at - t != G + 1 || cnt_a !== 32'd100) begin
            errors++;
            $display("FAIL restart_ignored: got latency=%0d count=%0d expected latency=%0d count=100", at - t, cnt_a, G + 1);
        end
        extra = 0;
        for (int i = 0; i < G + 100; i++) begin
            @(negedge clk);
            if (mv_a) extra++;
        end
        checks++;
        if (extra != 0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL restart_extra: got extra_valid=%0d busy=%b expected 0 and 0", extra, busy_a);
        end
    endtask

    task automatic test_reset_mid();
        int t, at, extra;
        bit ok;
        set_sig(1'b1, 5, 5);
        do_start(0, t);
        while (cyc < t + 600) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy_a, mv_a, cnt_a, ovf_a} !== 35'd0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b valid=%b count=%0d ovf=%b expected all 0", busy_a, mv_a, cnt_a, ovf_a);
        end
        wait_cycles(2);
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < G + 100; i++) begin
            @(negedge clk);
            if (mv_a || busy_a) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: got %0d busy/valid cycles expected 0", extra);
        end
        do_start(0, t);
        wait_valid(0, G + 50, at, ok);
        checks++;
        if (!ok || cnt_a !== 32'd100) begin
            errors++;
            $display("FAIL reset_mid_fresh: got count=%0d ok=%b expected 100", cnt_a, ok);
        end
    endtask

    task automatic test_saturate();
        int t, at;
        bit ok;
        set_sig(1'b1, 5, 5);
        do_start(1, t);
        wait_valid(1, G + 50, at, ok);
        checks++;
        if (!ok || cnt_b !== 4'd15 || ovf_b !== 1'b1) begin
            errors++;
            $display("FAIL sat_window: got count=%0d ovf=%b expected 15 ovf=1", cnt_b, ovf_b);
        end
        set_sig(1'b0, 5, 5);
        do_start(1, t);
        wait_valid(1, G + 50, at, ok);
        checks++;
        if (!ok || cnt_b !== 4'd0 || ovf_b !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear: got count=%0d ovf=%b expected 0 ovf=0", cnt_b, ovf_b);
        end
    endtask

    task automatic test_random();
        int t, at, exp;
        bit ok;
        for (int k = 0; k < 4; k++) begin
            set_sig(1'b1, $urandom_range(2, 9), $urandom_range(2, 9));
            wait_cycles($urandom_range(0, 20));
            do_start(0, t);
            wait_valid(0, G + 50, at, ok);
            exp = model_count(t, G);
            checks++;
            if (!ok || cnt_a !== exp || ovf_a !== 1'b0) begin
                errors++;
                $display("FAIL random_%0d: got count=%0d ovf=%b expected %0d ovf=0 (hi=%0d lo=%0d)", k, cnt_a, ovf_a, exp, hi_len, lo_len);
            end
        end
    endtask

    task automatic test_continuous();
        int t, at, sum, exp;
        bit ok;
        set_sig(1'b1, 5, 5);
        wait_cycles($urandom_range(0, 9));
        do_start(2, t);
        sum = 0;
        for (int k = 0; k < 5; k++) begin
            wait_valid(2, G + 50, at, ok);
            exp = model_count(t + k * G, G);
            checks++;
            if (!ok || at != t + 1 + G * (k + 1)) begin
                errors++;
                $display("FAIL cont_period_%0d: got cycle %0d expected %0d", k, at - t, 1 + G * (k + 1));
            end
            checks++;
            if (cnt_c !== 32'd100 || cnt_c !== exp || ovf_c !== 1'b0) begin
                errors++;
                $display("FAIL cont_count_%0d: got %0d ovf=%b expected 100 (model %0d)", k, cnt_c, ovf_c, exp);
            end
            sum += cnt_c;
        end
        checks++;
        if (sum != 500 || busy_c !== 1'b1) begin
            errors++;
            $display("FAIL cont_sum: got sum=%0d busy=%b expected 500 busy=1", sum, busy_c);
        end
    endtask

    initial begin
        test_reset();
        test_oneshot("p10", 1'b1, 5, 5, 100);
        test_oneshot("p4", 1'b1, 2, 2, 250);
        test_oneshot("low", 1'b0, 5, 5, 0);
        test_back_to_back();
        test_restart_ignored();
        test_reset_mid();
        test_saturate();
        test_random();
        test_continuous();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
